// File: rtl/mem_if_pkg.sv
// Shared definitions for the Data_Memory line-port arbiter: widths, FSM
// encoding and requester indices.
package mem_if_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector: on a tie the requester that did
// not win last time is picked.
module rr_pick2
  import mem_if_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? ~last : (req1 ? REQ_D : REQ_I);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single Data_Memory line port between the I-cache (m0) and
// D-cache (m1) controllers; request held until ack, watchdog on lost acks.
module mem_port_arbiter
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = mem_if_pkg::ADDR_W,
  parameter int LINE_W  = mem_if_pkg::LINE_W,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [LINE_W-1:0] rdata_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              owner_o,
  output logic              busy_o,
  output logic              err_o
);
  arb_state_e      state;
  logic [TO_W-1:0] wdog;
  logic            rr_last;
  logic            pick_valid;
  logic            pick_win;
  logic            ack_ok;

  rr_pick2 u_pick (
    .req0   (m0_req_i),
    .req1   (m1_req_i),
    .last   (rr_last),
    .valid  (pick_valid),
    .winner (pick_win)
  );

  // Acks only exist inside BUSY, so stray mem acks after abort/reset vanish.
  assign ack_ok   = (state == BUSY) && mem_ack_i;
  assign m0_ack_o = ack_ok && (owner_o == REQ_I);
  assign m1_ack_o = ack_ok && (owner_o == REQ_D);
  assign rdata_o  = mem_data_i;
  assign busy_o   = (state == BUSY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      owner_o      <= REQ_I;
      err_o        <= 1'b0;
      wdog         <= '0;
      rr_last      <= REQ_I;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            mem_enable_o <= 1'b1;
            mem_write_o  <= pick_win ? m1_write_i : m0_write_i;
            mem_addr_o   <= pick_win ? m1_addr_i  : m0_addr_i;
            mem_data_o   <= pick_win ? m1_data_i  : m0_data_i;
            owner_o      <= pick_win;
            rr_last      <= pick_win;
            state        <= BUSY;
          end
        end
        BUSY: begin
          wdog <= wdog + 1'b1;
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            state        <= GAP;
          end else if (wdog == TO_W'(TIMEOUT - 1)) begin
            err_o        <= 1'b1;
            mem_enable_o <= 1'b0;
            state        <= GAP;
          end
        end
        GAP: begin
          // Dead cycle lets the served requester drop req before re-arbitration.
          wdog  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_req_i, m0_write_i, m1_req_i, m1_write_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [LW-1:0] m0_data_i, m1_data_i;
  logic          m0_ack_o, m1_ack_o;
  logic [LW-1:0] rdata_o, mem_data_o, mem_data_i;
  logic          mem_enable_o, mem_write_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic          owner_o, busy_o, err_o;

  int vectors = 0;
  int errs    = 0;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(64), .TO_W(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o),
    .m1_req_i(m1_req_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o),
    .rdata_o(rdata_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse mem_ack_i for the current cycle and check which ack fires.
  task automatic ack_now(input string tag, input logic exp0, input logic exp1);
    mem_ack_i = 1'b1;
    #1;
    chk({tag, "_m0ack"}, LW'(m0_ack_o), LW'(exp0));
    chk({tag, "_m1ack"}, LW'(m1_ack_o), LW'(exp1));
    tick();
    mem_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  logic [LW-1:0] line_a, line_w;
  int            ack_cnt;

  initial begin
    rst_i = 1'b1;
    m0_req_i = 0; m0_write_i = 0; m0_addr_i = '0; m0_data_i = '0;
    m1_req_i = 0; m1_write_i = 0; m1_addr_i = '0; m1_data_i = '0;
    mem_ack_i = 0; mem_data_i = '0;
    line_a = {8{32'hDEAD_BEEF}};
    line_w = {32{8'hA5}};
    tick(); tick();
    rst_i = 1'b0;

    // Reset state
    chk("rst_en",    LW'(mem_enable_o), '0);
    chk("rst_busy",  LW'(busy_o), '0);
    chk("rst_err",   LW'(err_o), '0);
    chk("rst_owner", LW'(owner_o), '0);
    chk("rst_addr",  LW'(mem_addr_o), '0);
    chk("rst_wr",    LW'(mem_write_o), '0);

    // Single read on m1, memory acks 10 cycles after enable
    m1_req_i = 1; m1_write_i = 0; m1_addr_i = 32'h0000_0400;
    #1 chk("rd_en_pre", LW'(mem_enable_o), '0);
    tick();
    chk("rd_en",    LW'(mem_enable_o), LW'(1'b1));
    chk("rd_addr",  LW'(mem_addr_o), LW'(32'h400));
    chk("rd_owner", LW'(owner_o), LW'(1'b1));
    chk("rd_busy",  LW'(busy_o), LW'(1'b1));
    ack_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      ack_cnt += int'(m0_ack_o) + int'(m1_ack_o);
    end
    chk("rd_noearly", LW'(ack_cnt), '0);
    mem_data_i = line_a;
    mem_ack_i  = 1'b1;
    #1;
    chk("rd_m1ack", LW'(m1_ack_o), LW'(1'b1));
    chk("rd_m0ack", LW'(m0_ack_o), '0);
    chk("rd_rdata", rdata_o, line_a);
    tick();
    mem_ack_i = 1'b0; m1_req_i = 0;
    chk("rd_gap_en",   LW'(mem_enable_o), '0);
    chk("rd_gap_busy", LW'(busy_o), '0);
    tick();
    chk("rd_idle_en", LW'(mem_enable_o), '0);

    // Tie after reset: m1 first, then m0, then m1 again
    do_reset();
    m0_req_i = 1; m1_req_i = 1;
    m0_addr_i = 32'h10; m1_addr_i = 32'h20;
    tick();
    chk("tie1_owner", LW'(owner_o), LW'(1'b1));
    chk("tie1_addr",  LW'(mem_addr_o), LW'(32'h20));
    ack_now("tie1", 1'b0, 1'b1);
    m1_req_i = 0;
    chk("tie1_gap_en", LW'(mem_enable_o), '0);
    tick();
    tick();
    chk("tie2_owner", LW'(owner_o), '0);
    chk("tie2_en",    LW'(mem_enable_o), LW'(1'b1));
    ack_now("tie2", 1'b1, 1'b0);
    m0_req_i = 0;
    tick();
    m0_req_i = 1; m1_req_i = 1;
    tick();
    chk("tie3_owner", LW'(owner_o), LW'(1'b1));
    ack_now("tie3", 1'b0, 1'b1);
    m0_req_i = 0; m1_req_i = 0;
    tick();

    // Frozen write request on m0
    m0_req_i = 1; m0_write_i = 1; m0_addr_i = 32'h80; m0_data_i = line_w;
    tick();
    chk("wr_wr",   LW'(mem_write_o), LW'(1'b1));
    chk("wr_addr", LW'(mem_addr_o), LW'(32'h80));
    m0_addr_i = 32'hC0; m0_data_i = '0; m0_write_i = 0;
    tick(); tick(); tick();
    chk("wr_frz_addr", LW'(mem_addr_o), LW'(32'h80));
    chk("wr_frz_data", mem_data_o, line_w);
    chk("wr_frz_wr",   LW'(mem_write_o), LW'(1'b1));
    chk("wr_ack_addr", LW'(mem_addr_o), LW'(32'h80));
    ack_now("wr", 1'b1, 1'b0);
    m0_req_i = 0;
    tick();

    // Timeout: 64 BUSY cycles with no ack
    m0_req_i = 1; m0_write_i = 0; m0_addr_i = 32'h100;
    tick();
    for (int i = 0; i < 63; i++) tick();
    chk("to_last_en",  LW'(mem_enable_o), LW'(1'b1));
    chk("to_last_err", LW'(err_o), '0);
    tick();
    chk("to_err",  LW'(err_o), LW'(1'b1));
    chk("to_en",   LW'(mem_enable_o), '0);
    chk("to_busy", LW'(busy_o), '0);
    mem_ack_i = 1'b1;
    #1 chk("to_stray_m0ack", LW'(m0_ack_o), '0);
    m0_req_i = 0;
    tick();
    mem_ack_i = 1'b0;
    chk("to_idle_busy", LW'(busy_o), '0);
    m1_req_i = 1; m1_addr_i = 32'h300;
    tick();
    chk("to_m1_owner", LW'(owner_o), LW'(1'b1));
    ack_now("to_m1", 1'b0, 1'b1);
    chk("to_err_sticky", LW'(err_o), LW'(1'b1));
    m1_req_i = 0;
    tick();

    // Reset mid-BUSY on cycle 5, late ack on cycle 12
    m0_req_i = 1; m0_addr_i = 32'h200;
    tick();
    tick(); tick(); tick();
    rst_i = 1; m0_req_i = 0;
    tick();
    rst_i = 0;
    chk("rstm_en",    LW'(mem_enable_o), '0);
    chk("rstm_busy",  LW'(busy_o), '0);
    chk("rstm_err",   LW'(err_o), '0);
    chk("rstm_owner", LW'(owner_o), '0);
    chk("rstm_addr",  LW'(mem_addr_o), '0);
    for (int i = 0; i < 6; i++) tick();
    mem_ack_i = 1'b1;
    #1;
    chk("rstm_late_m0", LW'(m0_ack_o), '0);
    chk("rstm_late_m1", LW'(m1_ack_o), '0);
    tick();
    mem_ack_i = 1'b0;

    // Starvation: m0 raised during m1 BUSY wins the next IDLE
    m1_req_i = 1; m1_addr_i = 32'h500; m0_addr_i = 32'h600;
    tick();
    chk("sv_owner1", LW'(owner_o), LW'(1'b1));
    tick(); tick();
    m0_req_i = 1;
    tick(); tick();
    chk("sv_frz_addr", LW'(mem_addr_o), LW'(32'h500));
    ack_now("sv1", 1'b0, 1'b1);
    chk("sv_gap_en",    LW'(mem_enable_o), '0);
    chk("sv_gap_owner", LW'(owner_o), LW'(1'b1));
    tick();
    tick();
    chk("sv_owner0", LW'(owner_o), '0);
    chk("sv_addr0",  LW'(mem_addr_o), LW'(32'h600));
    ack_now("sv2", 1'b1, 1'b0);
    m0_req_i = 0;
    tick();
    tick();
    chk("sv_owner1b", LW'(owner_o), LW'(1'b1));
    ack_now("sv3", 1'b0, 1'b1);
    m1_req_i = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
